// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: registered start/game/end screen controller with debounced start switch.
// Optional: define GAME_AUTO_RESTART_EN to relaunch a game from S_END after a further END_HOLD cycles while the switch stays on.
module game_mode_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int RST_PULSE  = 16,
    parameter int END_HOLD   = 75000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic       game_over,
    output logic [1:0] mode,
    output logic       start_ena,
    output logic       game_ena,
    output logic       end_ena,
    output logic       start_rst,
    output logic       game_rst,
    output logic       end_rst,
    output logic       restart_ok
);
    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int HW = $clog2(END_HOLD) + 1;
    localparam int CW = $clog2(RST_PULSE > END_HOLD ? RST_PULSE : END_HOLD) + 1;

    typedef enum logic [1:0] {S_START, S_LAUNCH, S_GAME, S_END} state_t;

    state_t        state;
    logic          meta, sync, start_db;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] cnt;
    logic [7:0]    outs;

    // {mode, start_ena, game_ena, end_ena, start_rst, game_rst, end_rst} for each screen
    function automatic logic [7:0] dec(input state_t s);
        return s == S_START  ? 8'b00_100_011 :
               s == S_LAUNCH ? 8'b01_000_111 :
               s == S_GAME   ? 8'b01_010_101 : 8'b11_001_100;
    endfunction

    assign {mode, start_ena, game_ena, end_ena, start_rst, game_rst, end_rst} = outs;

    // two-flop synchroniser for the asynchronous slide switch
    always_ff @(posedge clk or posedge rst)
        if (rst) {sync, meta} <= 2'b00;
        else {sync, meta} <= {meta, start_game};

    // debounced level follows sync only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            deb_cnt  <= '0;
            start_db <= 1'b0;
        end else if (sync == start_db) deb_cnt <= '0;
        else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            start_db <= sync;
            deb_cnt  <= '0;
        end else deb_cnt <= deb_cnt + 1'b1;

    // screen sequencer; outputs are loaded together with the state register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= S_START;
            outs       <= dec(S_START);
            cnt        <= '0;
            hold_cnt   <= '0;
            restart_ok <= 1'b0;
        end else case (state)
            S_START:
                if (start_db) begin
                    state <= S_LAUNCH;
                    outs  <= dec(S_LAUNCH);
                    cnt   <= '0;
                end
            S_LAUNCH:
                if (!start_db) begin
                    state <= S_START;
                    outs  <= dec(S_START);
                end else if (cnt == CW'(RST_PULSE - 1)) begin
                    state <= S_GAME;
                    outs  <= dec(S_GAME);
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
            S_GAME:
                if (!start_db) begin
                    state <= S_START;
                    outs  <= dec(S_START);
                end else if (game_over && cnt != '0) begin
                    state      <= S_END;
                    outs       <= dec(S_END);
                    cnt        <= '0;
                    hold_cnt   <= '0;
                    restart_ok <= 1'b0;
                end else cnt <= CW'(1);
            S_END: begin
                if (hold_cnt != HW'(END_HOLD - 1)) hold_cnt <= hold_cnt + 1'b1;
                else restart_ok <= 1'b1;
                if (restart_ok && !start_db) begin
                    state      <= S_START;
                    outs       <= dec(S_START);
                    hold_cnt   <= '0;
                    restart_ok <= 1'b0;
                end
`ifdef GAME_AUTO_RESTART_EN
                else if (restart_ok) begin
                    if (cnt == CW'(END_HOLD - 1)) begin
                        state      <= S_LAUNCH;
                        outs       <= dec(S_LAUNCH);
                        cnt        <= '0;
                        hold_cnt   <= '0;
                        restart_ok <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                end
`endif
            end
        endcase
endmodule

// File: tb/tb_game_mode_ctrl.sv
// tb_game_mode_ctrl: scenario and random checks of game_mode_ctrl against a time-in-state reference model.
module tb_game_mode_ctrl;
    localparam int DEB = 4, RP = 3, EH = 10;
    localparam int ST = 0, LA = 1, GA = 2, EN = 3;
    localparam logic [8:0] RST_VEC = 9'b00_100_011_0;

    logic       clk = 1'b0, rst = 1'b1, start_game = 1'b0, game_over = 1'b0;
    logic [1:0] mode;
    logic       start_ena, game_ena, end_ena, start_rst, game_rst, end_rst, restart_ok;
    logic [8:0] dut_vec;
    int         checks = 0, errors = 0;

    int ms, mt;
    bit mdb;
    bit sq[$];
    bit hist[$];

    assign dut_vec = {mode, start_ena, game_ena, end_ena, start_rst, game_rst, end_rst, restart_ok};

    always #5 clk = ~clk;

    game_mode_ctrl #(.DEB_CYCLES(DEB), .RST_PULSE(RP), .END_HOLD(EH)) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .game_over(game_over),
        .mode(mode), .start_ena(start_ena), .game_ena(game_ena), .end_ena(end_ena),
        .start_rst(start_rst), .game_rst(game_rst), .end_rst(end_rst), .restart_ok(restart_ok)
    );

    task automatic model_reset();
        ms = ST;
        mt = 0;
        mdb = 1'b0;
        sq = '{1'b0, 1'b0};
        hist.delete();
    endtask

    task automatic model_step();
        bit sv, flip;
        int ns;
        sv = sq.pop_front();
        sq.push_back(start_game);
        hist.push_back(sv);
        if (hist.size() > DEB) void'(hist.pop_front());
        flip = hist.size() == DEB;
        foreach (hist[i]) if (hist[i] == mdb) flip = 1'b0;
        ns = ms;
        case (ms)
            ST: if (mdb) ns = LA;
            LA: if (!mdb) ns = ST; else if (mt + 1 == RP) ns = GA;
            GA: if (!mdb) ns = ST; else if (mt + 1 >= 2 && game_over) ns = EN;
            default: begin
                if (mt >= EH && !mdb) ns = ST;
`ifdef GAME_AUTO_RESTART_EN
                else if (mt + 1 == 2 * EH) ns = LA;
`endif
            end
        endcase
        mt = (ns == ms) ? mt + 1 : 0;
        ms = ns;
        if (flip) mdb = !mdb;
    endtask

    function automatic logic [8:0] exp_vec();
        case (ms)
            ST: return 9'b00_100_011_0;
            LA: return 9'b01_000_111_0;
            GA: return 9'b01_010_101_0;
            default: return {8'b11_001_100, mt >= EH};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        start_game = 1'b0;
        game_over = 1'b0;
        do_reset();
        checks++;
        if (dut_vec !== RST_VEC) begin errors++; $display("FAIL reset_values got %b want %b", dut_vec, RST_VEC); end
        for (int i = 0; i < 5; i++) begin
            game_over = 1'($urandom);
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_idle cyc %0d got %b want %b", i, dut_vec, exp_vec()); end
        end
        game_over = 1'b0;
    endtask

    task automatic test_debounce();
        int n;
        start_game = 1'b1;
        repeat (3) step();
        start_game = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (mode !== 2'b00 || dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch cyc %0d got %b want %b", i, dut_vec, exp_vec()); end
        end
        start_game = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL deb_track cyc %0d got %b want %b", n, dut_vec, exp_vec()); end
        end while (mode !== 2'b01 && n < 20);
        checks++;
        if (n !== 7) begin errors++; $display("FAIL deb_latency got %0d want 7", n); end
        for (int i = 0; i < RP; i++) begin
            checks++;
            if ({mode, game_ena, game_rst} !== 4'b01_0_1) begin errors++; $display("FAIL launch_pulse cyc %0d got %b want 0101", i, {mode, game_ena, game_rst}); end
            step();
        end
        checks++;
        if ({mode, game_ena, game_rst} !== 4'b01_1_0) begin errors++; $display("FAIL game_entry got %b want 0110", {mode, game_ena, game_rst}); end
    endtask

    task automatic reach_game(input logic go);
        int n = 0;
        do begin step(); n++; end while (game_ena !== 1'b1 && n < 30);
        checks++;
        if (game_ena !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL reach_game got %b want %b", dut_vec, exp_vec()); end
    endtask

    task automatic test_guard_and_end_hold();
        int k, e;
        do_reset();
        start_game = 1'b1;
        game_over = 1'b1;
        reach_game(1'b1);
        k = 0;
        while (game_ena === 1'b1 && k < 10) begin
            k++;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL guard_track cyc %0d got %b want %b", k, dut_vec, exp_vec()); end
        end
        checks++;
        if (k !== 2) begin errors++; $display("FAIL guard_len got %0d want 2", k); end
        checks++;
        if ({mode, end_ena, end_rst, game_ena} !== 5'b11_1_0_0) begin errors++; $display("FAIL guard_end got %b want 11100", {mode, end_ena, end_rst, game_ena}); end
        game_over = 1'b0;
        e = 0;
        repeat (2) begin step(); e++; end
        start_game = 1'b0;
        while (restart_ok !== 1'b1 && e < 30) begin
            step();
            e++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL hold_track cyc %0d got %b want %b", e, dut_vec, exp_vec()); end
        end
        checks++;
        if (e !== EH || end_ena !== 1'b1) begin errors++; $display("FAIL hold_len got %0d want %0d", e, EH); end
        step();
        checks++;
        if ({mode, start_ena, end_ena, restart_ok} !== 5'b00_1_0_0) begin errors++; $display("FAIL end_exit got %b want 00100", {mode, start_ena, end_ena, restart_ok}); end
    endtask

    task automatic test_priority();
        int n = 0;
        do_reset();
        start_game = 1'b1;
        reach_game(1'b1);
        repeat (3) step();
        start_game = 1'b0;
        while (mdb && n < 20) begin
            step();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL prio_track cyc %0d got %b want %b", n, dut_vec, exp_vec()); end
        end
        checks++;
        if (game_ena !== 1'b1 || mdb) begin errors++; $display("FAIL prio_setup game_ena %b db %b want 1 0", game_ena, mdb); end
        game_over = 1'b1;
        step();
        checks++;
        if ({mode, start_ena, end_ena} !== 4'b00_1_0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL priority got %b want %b", dut_vec, exp_vec()); end
        game_over = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        start_game = 1'b1;
        reach_game(1'b1);
        repeat (2) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin errors++; $display("FAIL async_reset got %b want %b", dut_vec, RST_VEC); end
        step();
        rst = 1'b0;
        do begin step(); n++; end while (mode !== 2'b01 && n < 20);
        checks++;
        if (n !== 7) begin errors++; $display("FAIL reset_deb_latency got %0d want 7", n); end
    endtask

    task automatic test_auto_restart();
        int n = 0;
        do_reset();
        start_game = 1'b1;
        game_over = 1'b1;
        reach_game(1'b1);
        repeat (2) step();
        checks++;
        if (end_ena !== 1'b1) begin errors++; $display("FAIL auto_reach_end got %b want 1", end_ena); end
        game_over = 1'b0;
        while (end_ena === 1'b1 && n < 40) begin
            step();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL auto_track cyc %0d got %b want %b", n, dut_vec, exp_vec()); end
        end
`ifdef GAME_AUTO_RESTART_EN
        checks++;
        if (n !== 2 * EH || {mode, game_rst} !== 3'b01_1) begin errors++; $display("FAIL auto_relaunch got %0d want %0d", n, 2 * EH); end
`else
        checks++;
        if (n !== 40 || {mode, restart_ok} !== 3'b11_1) begin errors++; $display("FAIL end_stays got %0d want 40", n); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        start_game = 1'b0;
        game_over = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) start_game = !start_game;
            game_over = $urandom_range(0, 5) == 0;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %b want %b", i, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_guard_and_end_hold();
        test_priority();
        test_async_reset();
        test_auto_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
